// File: rtl/queue_tracker.sv
// queue_tracker
//   Tracks how many people are waiting in a queue from the one-cycle count
//   pulses of the queue-sensor FSMs. It also keeps an estimated wait time,
//   wtime = WPP*(pcount+tcount-1)/tcount, which a multi-cycle restoring
//   divider produces.
//
// Ports
//   clk          in   1    rising-edge clock
//   reset        in   1    asynchronous, active-high
//   back_pulse   in   1    person entered at the back (one-cycle pulse)
//   front_pulse  in   1    person left at the front (one-cycle pulse)
//   tcount       in   TW   tellers on duty, sampled every cycle
//   pcount       out  PW   people currently in the queue
//   full         out  1    pcount == 2**PW-1
//   empty        out  1    pcount == 0
//   wtime        out  WTW  last completed wait-time estimate (saturating)
//   wtime_valid  out  1    wtime reflects the current pcount/tcount
//
// Optional build macro QT_ERR_FLAG_EN adds:
//   err_clr      in   1    clears err (a simultaneous set wins)
//   err          out  1    sticky flag for an ignored back-when-full or
//                          front-when-empty pulse
// Without the macro, ignored pulses are dropped silently.

module queue_tracker #(
  parameter int unsigned PW  = 3,
  parameter int unsigned TW  = 2,
  parameter int unsigned WPP = 3,
  parameter int unsigned WTW = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           back_pulse,
  input  logic           front_pulse,
  input  logic [TW-1:0]  tcount,
`ifdef QT_ERR_FLAG_EN
  input  logic           err_clr,
  output logic           err,
`endif
  output logic [PW-1:0]  pcount,
  output logic           full,
  output logic           empty,
  output logic [WTW-1:0] wtime,
  output logic           wtime_valid
);

  localparam int unsigned NUMW = WTW + TW;
  localparam int unsigned CW   = $clog2(NUMW + 1);
  localparam logic [PW-1:0] MAXP = '1;
  localparam logic [CW-1:0] LAST_ITER = CW'(NUMW - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // ---------------------------------------------------------------------------
  // Occupancy
  // ---------------------------------------------------------------------------
  logic inc;
  logic dec;
  logic pcount_upd;

  assign full  = (pcount == MAXP);
  assign empty = (pcount == '0);

  // A simultaneous back+front leaves pcount unchanged, so neither
  // saturation check applies to that case.
  assign inc        = back_pulse && !front_pulse && !full;
  assign dec        = front_pulse && !back_pulse && !empty;
  assign pcount_upd = inc || dec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcount <= '0;
    end else if (inc) begin
      pcount <= pcount + PW'(1);
    end else if (dec) begin
      pcount <= pcount - PW'(1);
    end
  end

`ifdef QT_ERR_FLAG_EN
  logic ignored;

  assign ignored = (back_pulse && !front_pulse && full) ||
                   (front_pulse && !back_pulse && empty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (ignored) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Change detection
  // ---------------------------------------------------------------------------
  logic [TW-1:0] tcount_q;
  logic          change;

  assign change = pcount_upd || (tcount != tcount_q);

  // ---------------------------------------------------------------------------
  // Divider datapath
  // ---------------------------------------------------------------------------
  logic [1:0]      state;
  logic [NUMW-1:0] num;       // dividend, shifted out MSB first
  logic [TW-1:0]   den;
  logic [TW-1:0]   rem;
  logic [NUMW-1:0] quo;
  logic [CW-1:0]   iter;
  logic            zero_res;

  logic            load_zero;
  logic [NUMW-1:0] load_num;
  logic [TW:0]     rem_sh;
  logic            q_bit;
  logic [TW-1:0]   rem_next;
  logic [WTW-1:0]  quo_sat;

  // When either operand is zero, the sum is not formed, so pcount+tcount-1
  // cannot underflow. The result is forced to zero at DONE instead.
  assign load_zero = (pcount == '0) || (tcount == '0);

  always_comb begin
    load_num = '0;
    if (!load_zero) begin
      load_num = NUMW'(WPP) * (NUMW'(pcount) + NUMW'(tcount) - NUMW'(1));
    end
  end

  // The partial remainder before the shift is below den, so the shifted
  // value fits in TW+1 bits. After a successful subtract it is again
  // below den, so the low TW bits of the difference are exact.
  assign rem_sh   = {rem, num[NUMW-1]};
  assign q_bit    = (rem_sh >= {1'b0, den});
  assign rem_next = q_bit ? (rem_sh[TW-1:0] - den) : rem_sh[TW-1:0];

  assign quo_sat = (|quo[NUMW-1:WTW]) ? '1 : quo[WTW-1:0];

  // ---------------------------------------------------------------------------
  // Divider control
  // ---------------------------------------------------------------------------
  // A change event in any state goes back to LOAD, which abandons a run in
  // progress. Because wtime is written only from DONE, an interrupted run
  // never reaches the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      tcount_q    <= '0;
      num         <= '0;
      den         <= '0;
      rem         <= '0;
      quo         <= '0;
      iter        <= '0;
      zero_res    <= 1'b0;
      wtime       <= '0;
      wtime_valid <= 1'b1;
    end else begin
      tcount_q <= tcount;
      if (change) begin
        state       <= S_LOAD;
        wtime_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_IDLE;
          end
          S_LOAD: begin
            num      <= load_num;
            den      <= tcount;
            zero_res <= load_zero;
            rem      <= '0;
            quo      <= '0;
            iter     <= '0;
            state    <= S_DIV;
          end
          S_DIV: begin
            num  <= {num[NUMW-2:0], 1'b0};
            rem  <= rem_next;
            quo  <= {quo[NUMW-2:0], q_bit};
            iter <= iter + CW'(1);
            if (iter == LAST_ITER) begin
              state <= S_DONE;
            end
          end
          default: begin
            wtime       <= zero_res ? '0 : quo_sat;
            wtime_valid <= 1'b1;
            state       <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
